// File: rtl/tt_load_drain_ovi.sv
`default_nettype none
// ============================================================================
// Module   : tt_load_drain_ovi
// Purpose  : Load-buffer drain engine for the OVI vector load path. Returned
//            load data is held in an LQ-indexed buffer. A drain request
//            (start lqid + entry count) is walked in order with wrap-around;
//            each valid entry is presented to the VRF writeback port and its
//            retirement is reported back to the scoreboard via o_lq_commit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n             : clock, synchronous active-low reset
//   i_load_valid/lqid/data   : buffer fill from OVI load return
//   i_rd                     : scalar result stored with each fill (macro)
//   i_drain_load_buffer      : drain request, with i_drain_lqid_start and
//                              i_drain_ref_count (0 = nothing to drain)
//   o_draining_load_buffer   : engine busy (DRAIN or FINISH)
//   o_wb_valid/lqid/data     : writeback beat, accepted with i_wb_ready
//   o_lq_commit/o_dest_lqid  : one entry retired this cycle
//   o_fill_overflow          : sticky, a fill hit an already-valid entry
//   o_rd_valid/lqid, o_rd    : scalar result on the last commit (macro)
// Configuration
//   TT_LOAD_DRAIN_RD_EN : when defined, a 64-bit scalar result is stored per
//                         entry and forwarded on the final commit of a drain.
//                         When undefined the o_rd* outputs are tied to zero.
// ============================================================================
module tt_load_drain_ovi #(
    parameter int  DATA_WIDTH = 512,
    parameter int  LQ_DEPTH   = 8,
    localparam int LQW        = $clog2(LQ_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load_valid,
    input  logic [LQW-1:0]        i_load_lqid,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_drain_load_buffer,
    input  logic [LQW-1:0]        i_drain_lqid_start,
    input  logic [2:0]            i_drain_ref_count,
    output logic                  o_draining_load_buffer,
    output logic                  o_wb_valid,
    input  logic                  i_wb_ready,
    output logic [LQW-1:0]        o_wb_lqid,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_lq_commit,
    output logic [LQW-1:0]        o_dest_lqid,
    output logic                  o_fill_overflow,
    input  logic [63:0]           i_rd,
    output logic                  o_rd_valid,
    output logic [LQW-1:0]        o_rd_lqid,
    output logic [63:0]           o_rd
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [LQW-1:0]        ptr;
    logic [LQW-1:0]        ptr_inc;
    logic [2:0]            remaining;
    logic [LQ_DEPTH-1:0]   valid;
    logic [DATA_WIDTH-1:0] data_mem [LQ_DEPTH];
    logic                  fill_overflow;
    logic                  pop;
    logic                  fill_accept;

    // Explicit wrap keeps the walk correct for non-power-of-two depths.
    assign ptr_inc = (ptr == LQW'(LQ_DEPTH - 1)) ? '0 : ptr + 1'b1;

    // A fill may land on the entry being popped this cycle: the pop clears
    // the old beat and the fill re-arms the entry, so it is not an overflow.
    assign fill_accept = i_load_valid &
                         (~valid[i_load_lqid] | (pop & (ptr == i_load_lqid)));

    assign o_fill_overflow = fill_overflow;

    // ------------------------------------------------------------------
    // FSM state and drain pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && i_drain_load_buffer) begin
                ptr       <= i_drain_lqid_start;
                remaining <= i_drain_ref_count;
            end else if (pop) begin
                ptr       <= ptr_inc;
                remaining <= remaining - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and writeback outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next             = state;
        o_draining_load_buffer = 1'b0;
        o_wb_valid             = 1'b0;
        o_wb_lqid              = '0;
        o_wb_data              = '0;
        o_lq_commit            = 1'b0;
        o_dest_lqid            = '0;
        pop                    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_drain_load_buffer) begin
                    state_next = (i_drain_ref_count != 3'd0) ? ST_DRAIN : ST_FINISH;
                end
            end
            ST_DRAIN: begin
                o_draining_load_buffer = 1'b1;
                o_wb_valid             = valid[ptr];
                o_wb_lqid              = ptr;
                o_wb_data              = data_mem[ptr];
                pop                    = valid[ptr] & i_wb_ready;
                if (pop) begin
                    o_lq_commit = 1'b1;
                    o_dest_lqid = ptr;
                    if (remaining == 3'd1) begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                o_draining_load_buffer = 1'b1;
                state_next             = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Entry valid bits and sticky overflow. The fill assignment follows the
    // pop clear so a same-entry fill wins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid         <= '0;
            fill_overflow <= 1'b0;
        end else begin
            if (pop) begin
                valid[ptr] <= 1'b0;
            end
            if (fill_accept) begin
                valid[i_load_lqid] <= 1'b1;
            end
            if (i_load_valid && !fill_accept) begin
                fill_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; it is only observed behind valid.
    always_ff @(posedge clk) begin
        if (fill_accept) begin
            data_mem[i_load_lqid] <= i_load_data;
        end
    end

`ifdef TT_LOAD_DRAIN_RD_EN
    logic [63:0] rd_mem [LQ_DEPTH];
    logic        last_pop;

    assign last_pop = pop & (remaining == 3'd1);

    always_ff @(posedge clk) begin
        if (fill_accept) begin
            rd_mem[i_load_lqid] <= i_rd;
        end
    end

    assign o_rd_valid = last_pop;
    assign o_rd_lqid  = last_pop ? ptr : '0;
    assign o_rd       = last_pop ? rd_mem[ptr] : 64'd0;
`else
    logic unused_rd;
    assign unused_rd  = ^i_rd;
    assign o_rd_valid = 1'b0;
    assign o_rd_lqid  = '0;
    assign o_rd       = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tt_load_drain_ovi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_load_drain_ovi
// Purpose  : Self-checking bench for tt_load_drain_ovi. A queue-based model
//            (pending lqids of the active drain plus a busy flag) predicts
//            every output each cycle; directed sequences pin the model with
//            literal expectations, then a randomized phase runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tt_load_drain_ovi;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_valid;
    logic [2:0]   load_lqid;
    logic [511:0] load_data;
    logic         drain_req;
    logic [2:0]   drain_start;
    logic [2:0]   drain_count;
    logic         draining;
    logic         wb_valid;
    logic         wb_ready;
    logic [2:0]   wb_lqid;
    logic [511:0] wb_data;
    logic         lq_commit;
    logic [2:0]   dest_lqid;
    logic         fill_ovf;
    logic [63:0]  rd_in;
    logic         rd_valid;
    logic [2:0]   rd_lqid;
    logic [63:0]  rd_out;

    int errors = 0;
    int checks = 0;
    int n_commits = 0;

    always #5 clk = ~clk;

    tt_load_drain_ovi #(.DATA_WIDTH(512), .LQ_DEPTH(8)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .i_load_valid           (load_valid),
        .i_load_lqid            (load_lqid),
        .i_load_data            (load_data),
        .i_drain_load_buffer    (drain_req),
        .i_drain_lqid_start     (drain_start),
        .i_drain_ref_count      (drain_count),
        .o_draining_load_buffer (draining),
        .o_wb_valid             (wb_valid),
        .i_wb_ready             (wb_ready),
        .o_wb_lqid              (wb_lqid),
        .o_wb_data              (wb_data),
        .o_lq_commit            (lq_commit),
        .o_dest_lqid            (dest_lqid),
        .o_fill_overflow        (fill_ovf),
        .i_rd                   (rd_in),
        .o_rd_valid             (rd_valid),
        .o_rd_lqid              (rd_lqid),
        .o_rd                   (rd_out)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: the active drain is a queue of lqids still to
    // retire; busy with an empty queue is the one-cycle wrap-up.
    // ------------------------------------------------------------------
    bit           m_started = 1'b0;
    bit [7:0]     m_valid;
    logic [511:0] m_data [8];
    logic [63:0]  m_rd [8];
    bit           m_busy;
    bit           m_ovf;
    int           q[$];
    bit           mp;
    int           mh;
    bit           macc;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_valid   = '0;
            m_busy    = 1'b0;
            m_ovf     = 1'b0;
            q.delete();
            m_started = 1'b1;
        end else if (m_started) begin
            mh   = (q.size() > 0) ? q[0] : 0;
            mp   = m_busy && (q.size() > 0) && m_valid[mh] && (wb_ready === 1'b1);
            macc = !m_valid[load_lqid] || (mp && mh == int'(load_lqid));
            if (mp) m_valid[mh] = 1'b0;
            if (load_valid) begin
                if (macc) begin
                    m_valid[load_lqid] = 1'b1;
                    m_data[load_lqid]  = load_data;
                    m_rd[load_lqid]    = rd_in;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (!m_busy) begin
                if (drain_req) begin
                    m_busy = 1'b1;
                    for (int k = 0; k < int'(drain_count); k++)
                        q.push_back((int'(drain_start) + k) % 8);
                end
            end else if (q.size() == 0) begin
                m_busy = 1'b0;
            end else if (mp) begin
                void'(q.pop_front());
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    bit ind, ev, ec, erv;
    int eh;
    always @(negedge clk) begin
        if (m_started) begin
            ind = m_busy && (q.size() > 0);
            eh  = ind ? q[0] : 0;
            ev  = ind && m_valid[eh];
            ec  = ev && (wb_ready === 1'b1);
`ifdef TT_LOAD_DRAIN_RD_EN
            erv = ec && (q.size() == 1);
`else
            erv = 1'b0;
`endif
            chk("m_draining", draining, m_busy);
            chk("m_wb_valid", wb_valid, ev);
            chk("m_wb_lqid", wb_lqid, ind ? eh : 0);
            if (ev) chk("m_wb_data", wb_data, m_data[eh]);
            chk("m_commit", lq_commit, ec);
            chk("m_dest_lqid", dest_lqid, ec ? eh : 0);
            chk("m_overflow", fill_ovf, m_ovf);
            chk("m_rd_valid", rd_valid, erv);
            chk("m_rd_lqid", rd_lqid, erv ? eh : 0);
            chk("m_rd", rd_out, erv ? m_rd[eh] : 64'd0);
            if (lq_commit === 1'b1) n_commits++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int lq, input logic [511:0] d, input logic [63:0] r);
        load_valid = 1'b1;
        load_lqid  = 3'(lq);
        load_data  = d;
        rd_in      = r;
        tick();
        load_valid = 1'b0;
    endtask

    // Returns in the first cycle after the request edge.
    task automatic request(input int start, input int count);
        drain_req   = 1'b1;
        drain_start = 3'(start);
        drain_count = 3'(count);
        tick();
        drain_req = 1'b0;
    endtask

    logic [511:0] dsave [8];
    logic [511:0] da, db;
    int           c0;
    int           wrap_exp [4];

    initial begin
        reset_n     = 1'b0;
        load_valid  = 1'b0;
        load_lqid   = '0;
        load_data   = '0;
        drain_req   = 1'b0;
        drain_start = '0;
        drain_count = '0;
        wb_ready    = 1'b1;
        rd_in       = '0;
        tick();
        tick();
        chk("rst_draining", draining, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_commit", lq_commit, 0);
        chk("rst_overflow", fill_ovf, 0);
        reset_n = 1'b1;
        tick();

        // In-order drain of 2,3,4
        for (int lq = 2; lq <= 4; lq++) begin
            dsave[lq] = rnd512();
            fill(lq, dsave[lq], 64'd0);
        end
        request(2, 3);
        for (int k = 0; k < 3; k++) begin
            chk("s1_draining", draining, 1);
            chk("s1_wb_lqid", wb_lqid, 2 + k);
            chk("s1_dest", dest_lqid, 2 + k);
            chk("s1_commit", lq_commit, 1);
            chk("s1_data", wb_data, dsave[2 + k]);
            tick();
        end
        chk("s1_finish_draining", draining, 1);
        chk("s1_finish_commit", lq_commit, 0);
        tick();
        chk("s1_idle", draining, 0);

        // Wrap-around 6,7,0,1
        wrap_exp = '{6, 7, 0, 1};
        for (int k = 0; k < 4; k++) fill(wrap_exp[k], rnd512(), 64'd0);
        request(6, 4);
        for (int k = 0; k < 4; k++) begin
            chk("s2_dest", dest_lqid, wrap_exp[k]);
            chk("s2_commit", lq_commit, 1);
            tick();
        end
        tick();
        // Entries must be free again: refilling them cannot overflow.
        for (int k = 0; k < 4; k++) fill(wrap_exp[k], rnd512(), 64'd0);
        chk("s2_refill_no_overflow", fill_ovf, 0);
        request(6, 4);
        for (int k = 0; k < 6; k++) tick();

        // Late fill with backpressure on lqid 5
        c0 = n_commits;
        request(5, 1);
        chk("s3_t1_draining", draining, 1);
        chk("s3_t1_wb_valid", wb_valid, 0);
        tick();
        chk("s3_t2_wb_valid", wb_valid, 0);
        tick();
        chk("s3_t3_wb_valid", wb_valid, 0);
        dsave[5]   = rnd512();
        load_valid = 1'b1;
        load_lqid  = 3'd5;
        load_data  = dsave[5];
        wb_ready   = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("s3_t4_wb_valid", wb_valid, 1);
        chk("s3_t4_data", wb_data, dsave[5]);
        chk("s3_t4_commit", lq_commit, 0);
        tick();
        chk("s3_t5_wb_valid", wb_valid, 1);
        chk("s3_t5_data", wb_data, dsave[5]);
        chk("s3_t5_commit", lq_commit, 0);
        wb_ready = 1'b1;
        #1;
        chk("s3_commit", lq_commit, 1);
        chk("s3_dest", dest_lqid, 5);
        tick();
        chk("s3_finish_draining", draining, 1);
        chk("s3_finish_wb_valid", wb_valid, 0);
        tick();
        chk("s3_idle", draining, 0);
        chk("s3_commit_count", n_commits - c0, 1);

        // Zero-count request, second request while busy is ignored
        c0 = n_commits;
        request(0, 0);
        drain_req = 1'b1;
        chk("s4_draining", draining, 1);
        chk("s4_commit", lq_commit, 0);
        drain_count = 3'd2;
        tick();
        drain_req = 1'b0;
        chk("s4_idle", draining, 0);
        tick();
        chk("s4_still_idle", draining, 0);
        chk("s4_commit_count", n_commits - c0, 0);

        // Overflow, then reset mid-drain
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        da = rnd512();
        db = rnd512();
        fill(1, da, 64'd0);
        fill(1, db, 64'd0);
        chk("s5_overflow", fill_ovf, 1);
        wb_ready = 1'b0;
        request(1, 2);
        chk("s5_wb_valid", wb_valid, 1);
        chk("s5_first_data_kept", wb_data, da);
        tick();
        chk("s5_stall_commit", lq_commit, 0);
        reset_n = 1'b0;
        tick();
        chk("s5_rst_draining", draining, 0);
        chk("s5_rst_wb_valid", wb_valid, 0);
        chk("s5_rst_wb_lqid", wb_lqid, 0);
        chk("s5_rst_wb_data", wb_data, 0);
        chk("s5_rst_commit", lq_commit, 0);
        chk("s5_rst_dest", dest_lqid, 0);
        chk("s5_rst_overflow", fill_ovf, 0);
        chk("s5_rst_rd_valid", rd_valid, 0);
        reset_n  = 1'b1;
        wb_ready = 1'b1;
        request(1, 1);
        chk("s5_after_draining", draining, 1);
        chk("s5_after_wb_valid", wb_valid, 0);
        tick();
        chk("s5_after_wb_valid2", wb_valid, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

`ifdef TT_LOAD_DRAIN_RD_EN
        fill(3, rnd512(), 64'hDEAD);
        fill(4, rnd512(), 64'hBEEF);
        request(3, 2);
        chk("s6_commit3", lq_commit, 1);
        chk("s6_rd_valid_first", rd_valid, 0);
        tick();
        chk("s6_rd_valid_last", rd_valid, 1);
        chk("s6_rd_lqid", rd_lqid, 4);
        chk("s6_rd", rd_out, 64'hBEEF);
        tick();
        tick();
`endif

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            reset_n     = ($urandom_range(0, 299) != 0);
            load_valid  = ($urandom_range(0, 9) < 4);
            load_lqid   = 3'($urandom);
            load_data   = rnd512();
            rd_in       = {$urandom, $urandom};
            drain_req   = ($urandom_range(0, 4) == 0);
            drain_start = 3'($urandom);
            drain_count = 3'($urandom);
            wb_ready    = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset_n    = 1'b1;
        load_valid = 1'b0;
        drain_req  = 1'b0;
        wb_ready   = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_load_drain_ovi.md
# tt_load_drain_ovi

Load-buffer drain engine for the OVI vector load path: the responder side of the scoreboard's drain handshake (`drain_load_buffer` / `draining_load_buffer`). It holds returned load data in an LQ-indexed buffer and accepts one drain request at a time (start lqid plus entry count). It walks the entries in order with wrap-around, hands each to the VRF writeback port, and pulses `lq_commit` with the lqid back to the scoreboard so its ref_count decrements.

## Interface
- DATA_WIDTH, 512, load data bits per LQ entry
- LQ_DEPTH, 8, buffer entries; lqid width LQW = $clog2(LQ_DEPTH) = 3
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- i_load_valid  in  1  fill strobe from OVI load return
- i_load_lqid  in  LQW  entry being filled
- i_load_data  in  DATA_WIDTH  fill data
- i_drain_load_buffer  in  1  drain request from scoreboard
- i_drain_lqid_start  in  LQW  first lqid of request
- i_drain_ref_count  in  3  entries to drain (0 = none)
- o_draining_load_buffer  out  1  engine busy
- o_wb_valid  out  1  writeback beat valid
- i_wb_ready  in  1  VRF accepts beat
- o_wb_lqid  out  LQW  lqid of beat
- o_wb_data  out  DATA_WIDTH  beat data
- o_lq_commit  out  1  one entry retired
- o_dest_lqid  out  LQW  retired lqid
- o_fill_overflow  out  1  sticky: fill hit a valid entry
- i_rd  in  64  scalar result (macro only)
- o_rd_valid  out  1  scalar result forward (macro only)
- o_rd_lqid  out  LQW  lqid for o_rd
- o_rd  out  64  scalar result

## Operation
- Storage: LQ_DEPTH × {valid, data}. Fill sets valid and writes data. Fill to an already-valid entry is dropped and sets o_fill_overflow, which stays set until reset.
- FSM states:
  - IDLE: o_draining=0.
  - DRAIN
  - FINISH: one cycle.
- IDLE: on i_drain_load_buffer=1, accept. Latch ptr=i_drain_lqid_start and remaining=i_drain_ref_count.
  - remaining≠0 → DRAIN.
  - remaining=0 → FINISH.
- DRAIN: o_wb_valid = valid[ptr]; o_wb_lqid=ptr; o_wb_data=data[ptr]. These are combinational from state and storage.
- Handshake (o_wb_valid & i_wb_ready):
  - o_lq_commit=1 and o_dest_lqid=ptr in the same cycle.
  - Next edge: valid[ptr] cleared, ptr = (ptr+1) mod LQ_DEPTH, remaining decremented.
  - If remaining was 1 → FINISH.
- FINISH → IDLE. o_draining=1 in DRAIN and FINISH.
- Requests in DRAIN/FINISH are ignored. The scoreboard holds its request until it sees draining low.
- A fill and the pop of the same ptr in one cycle: the pop is not bypassed. The beat presents on the next cycle.
- A fill to a ptr whose pop-clear happens in the same cycle: the fill wins, valid stays 1, and no overflow is flagged.
- Reset (including mid-drain): all valid cleared, state IDLE, remaining 0, and every output is 0.

## Timing
- Request sampled at edge T with IDLE → o_draining=1 from T+1.
- First beat is available at T+1 if its entry is already valid. N back-to-back ready beats occupy T+1..T+N, then FINISH at T+N+1, with o_draining=0 from T+N+2.
- ref_count=0: o_draining high exactly one cycle (T+1), no commits.
- i_wb_ready low stalls the beat. Outputs hold stable while o_wb_valid stays high.
- o_lq_commit is at most one per cycle, and never outside DRAIN.

## Configuration
- TT_LOAD_DRAIN_RD_EN defined:
  - Each fill also stores i_rd (64 b).
  - On the commit of the last entry of a drain: o_rd_valid=1, o_rd_lqid=ptr, o_rd=stored rd. These feed the scoreboard's rd update.
- Undefined: no rd storage; o_rd_valid, o_rd_lqid and o_rd are tied 0; i_rd is unused.

## Test plan
- Fill lqids 2,3,4; request start=2, count=3, ready=1:
  - beats 2,3,4 on T+1..T+3;
  - o_dest_lqid 2,3,4;
  - o_draining high T+1..T+4.
- Wrap: fill 6,7,0,1; request start=6, count=4 → commits 6,7,0,1; all four entries invalid afterwards.
- Late fill / backpressure: request start=5, count=1 with entry 5 empty.
  - o_wb_valid stays 0 until a fill at cycle T+3, beat at T+4.
  - With ready held low for 2 cycles, o_wb_data stays stable and there is exactly one commit.
- count=0 request → o_draining high one cycle, zero commits. A second request while busy is ignored.
- Fill lqid 1 twice without drain → o_fill_overflow=1 and the first data is retained. Reset mid-drain → all outputs 0 next cycle; a later drain of lqid 1 stalls (no valid entry).
- Macro on:
  - fill lqids 3,4 with i_rd=0xDEAD and 0xBEEF;
  - drain start=3, count=2 → o_rd_valid only on the lqid-4 commit, o_rd=0xBEEF.
